// File: rtl/alu_exec_unit.sv
// ============================================================================
// alu_exec_unit : multi-cycle ALU execute stage with valid/ready in and out.
// Optional macro ALU_EXEC_BARREL_SHIFT_EN selects a single-cycle shifter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package types;
  typedef enum logic [3:0] {
    ALU_FUNC_UNKNOWN = 4'd0,
    ALU_FUNC_ADD     = 4'd1,
    ALU_FUNC_SUB     = 4'd2,
    ALU_FUNC_AND     = 4'd3,
    ALU_FUNC_OR      = 4'd4,
    ALU_FUNC_XOR     = 4'd5,
    ALU_FUNC_SEQ     = 4'd6,
    ALU_FUNC_SLT     = 4'd7,
    ALU_FUNC_SLTU    = 4'd8,
    ALU_FUNC_SLL     = 4'd9,
    ALU_FUNC_SRL     = 4'd10,
    ALU_FUNC_SRA     = 4'd11
  } alu_func_t;

  typedef struct packed {
    logic      use_imm;
    logic      rd_write;
    alu_func_t alu_func;
  } control_t;
endpackage

module alu_exec_unit #(
  parameter  int XLEN    = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  types::control_t  in_ctrl,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [4:0]       out_rd,
  output logic             out_rd_write
);
  import types::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [XLEN-1:0]    result;
  logic [4:0]         rd;
  logic               rd_write;

  logic               accept;
  logic [XLEN-1:0]    op_b;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_result;
  logic               func_known;
  logic               start_shift;

  assign accept = in_valid && in_ready;
  assign op_b   = in_ctrl.use_imm ? in_imm : in_rs2;
  assign shamt  = op_b[SHAMT_W-1:0];

  always_comb begin
    alu_result  = '0;
    func_known  = 1'b1;
    start_shift = 1'b0;
    case (in_ctrl.alu_func)
      ALU_FUNC_ADD:  alu_result = in_rs1 + op_b;
      ALU_FUNC_SUB:  alu_result = in_rs1 - op_b;
      ALU_FUNC_AND:  alu_result = in_rs1 & op_b;
      ALU_FUNC_OR:   alu_result = in_rs1 | op_b;
      ALU_FUNC_XOR:  alu_result = in_rs1 ^ op_b;
      ALU_FUNC_SEQ:  alu_result = XLEN'(in_rs1 == op_b);
      ALU_FUNC_SLT:  alu_result = XLEN'($signed(in_rs1) < $signed(op_b));
      ALU_FUNC_SLTU: alu_result = XLEN'(in_rs1 < op_b);
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      ALU_FUNC_SLL:  alu_result = in_rs1 << shamt;
      ALU_FUNC_SRL:  alu_result = in_rs1 >> shamt;
      ALU_FUNC_SRA:  alu_result = $signed(in_rs1) >>> shamt;
`else
      // Iterative shifts start from A; a zero shift amount finishes right away.
      ALU_FUNC_SLL, ALU_FUNC_SRL, ALU_FUNC_SRA: begin
        alu_result  = in_rs1;
        start_shift = (shamt != '0);
      end
`endif
      default: begin
        alu_result = '0;
        func_known = 1'b0;
      end
    endcase
  end

  assign in_ready     = (state == IDLE) && !rst;
  assign out_valid    = (state == DONE);
  assign out_result   = result;
  assign out_rd       = rd;
  assign out_rd_write = rd_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      rd       <= '0;
      rd_write <= 1'b0;
    end else if (accept) begin
      result   <= alu_result;
      rd       <= in_rd;
      rd_write <= in_ctrl.rd_write && func_known;
    end
  end
`else
  alu_func_t          func;
  logic [SHAMT_W-1:0] cnt;
  logic [XLEN-1:0]    shift_one;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt == SHAMT_W'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_one = result;
    case (func)
      ALU_FUNC_SLL: shift_one = {result[XLEN-2:0], 1'b0};
      ALU_FUNC_SRL: shift_one = {1'b0, result[XLEN-1:1]};
      ALU_FUNC_SRA: shift_one = {result[XLEN-1], result[XLEN-1:1]};
      default:      shift_one = result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      rd       <= '0;
      rd_write <= 1'b0;
      func     <= ALU_FUNC_UNKNOWN;
      cnt      <= '0;
    end else if (accept) begin
      result   <= alu_result;
      rd       <= in_rd;
      rd_write <= in_ctrl.rd_write && func_known;
      func     <= in_ctrl.alu_func;
      cnt      <= shamt;
    end else if (state == SHIFT) begin
      result   <= shift_one;
      cnt      <= cnt - SHAMT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed results, latencies and handshakes.
`default_nettype none

module tb_alu_exec_unit;
  import types::*;

`ifdef ALU_EXEC_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  control_t    in_ctrl;
  logic [31:0] in_rs1, in_rs2, in_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_rd_write;

  int checks = 0;
  int errors = 0;
  int lat;
  bit busy_ok;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_rd_write(out_rd_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic control_t mk(input logic use_imm, input logic rdw, input alu_func_t f);
    control_t c;
    c.use_imm  = use_imm;
    c.rd_write = rdw;
    c.alu_func = f;
    return c;
  endfunction

  // Present one op at a negedge and hold it across the accepting posedge.
  task automatic send(input control_t c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [4:0] rdi);
    @(negedge clk);
    in_ctrl  = c;
    in_rs1   = a;
    in_rs2   = b;
    in_imm   = imm;
    in_rd    = rdi;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency = number of negedges after the accept edge up to the first out_valid.
  task automatic wait_out(output int l, output bit ok);
    l  = 0;
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      l++;
      if (out_valid) break;
      if (in_ready) ok = 1'b0;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input control_t c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rdi,
                        input logic [31:0] exp_res, input logic exp_rdw, input int exp_lat);
    send(c, a, b, imm, rdi);
    wait_out(lat, busy_ok);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, out_result, exp_res);
    chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rdi});
    chk({tag, "_rdw"}, {31'd0, out_rd_write}, {31'd0, exp_rdw});
    chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_ready_done"}, {31'd0, in_ready}, 32'd0);
    consume();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_rdw", {31'd0, out_rd_write}, 32'd0);
    rst = 1'b0;
    #1 chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    run_op("add_imm", mk(1, 1, ALU_FUNC_ADD), 32'h5, 32'h77, 32'hFFFF_FFFF, 5'd3, 32'h4, 1'b1, 1);
    run_op("sra4", mk(0, 1, ALU_FUNC_SRA), 32'h8000_0000, 32'h24, 32'h0, 5'd7,
           32'hF800_0000, 1'b1, BARREL ? 1 : 5);
    run_op("slt", mk(0, 1, ALU_FUNC_SLT), 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd4, 32'h1, 1'b1, 1);
    run_op("sltu", mk(0, 1, ALU_FUNC_SLTU), 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd4, 32'h0, 1'b1, 1);
    run_op("sll0", mk(1, 1, ALU_FUNC_SLL), 32'h1234, 32'h0, 32'h20, 5'd5, 32'h1234, 1'b1, 1);
    run_op("sub", mk(0, 1, ALU_FUNC_SUB), 32'h5, 32'h7, 32'h0, 5'd6, 32'hFFFF_FFFE, 1'b1, 1);
    run_op("seq", mk(1, 0, ALU_FUNC_SEQ), 32'hABCD, 32'h0, 32'hABCD, 5'd8, 32'h1, 1'b0, 1);
    run_op("srl4", mk(0, 1, ALU_FUNC_SRL), 32'hF000_0000, 32'h4, 32'h0, 5'd10,
           32'h0F00_0000, 1'b1, BARREL ? 1 : 5);
    run_op("sra_pos", mk(1, 1, ALU_FUNC_SRA), 32'h4000_0000, 32'h0, 32'h2, 5'd11,
           32'h1000_0000, 1'b1, BARREL ? 1 : 3);
    run_op("and", mk(0, 1, ALU_FUNC_AND), 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0, 5'd12,
           32'h0F00_0F00, 1'b1, 1);
    run_op("or_rd0", mk(0, 1, ALU_FUNC_OR), 32'hF000_0000, 32'h0000_000F, 32'h0, 5'd0,
           32'hF000_000F, 1'b1, 1);
    run_op("unknown", mk(0, 1, ALU_FUNC_UNKNOWN), 32'h1234, 32'h5678, 32'h0, 5'd13,
           32'h0, 1'b0, 1);
    run_op("nonenum", mk(0, 1, alu_func_t'(4'hF)), 32'h1234, 32'h5678, 32'h0, 5'd14,
           32'h0, 1'b0, 1);

    // Backpressure: XOR result must hold for 6 cycles while out_ready is low.
    send(mk(0, 1, ALU_FUNC_XOR), 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0, 5'd9);
    wait_out(lat, busy_ok);
    chk("xor_lat", lat, 1);
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", out_result, 32'hF00F_F00F);
      chk("bp_rd", {27'd0, out_rd}, 32'd9);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    consume();
    @(negedge clk);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_data_kept", out_result, 32'hF00F_F00F);
    run_op("after_bp", mk(1, 1, ALU_FUNC_ADD), 32'h10, 32'h0, 32'h20, 5'd1, 32'h30, 1'b1, 1);

    // Reset in the middle of a 31-bit shift (or in DONE for the barrel build).
    send(mk(0, 1, ALU_FUNC_SLL), 32'h1, 32'h1F, 32'h0, 5'd15);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", out_result, 32'd0);
    chk("mid_rst_rd", {27'd0, out_rd}, 32'd0);
    chk("mid_rst_rdw", {31'd0, out_rd_write}, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    run_op("post_rst_add", mk(0, 1, ALU_FUNC_ADD), 32'h2, 32'h3, 32'h0, 5'd2, 32'h5, 1'b1, 1);
    run_op("sll31", mk(0, 1, ALU_FUNC_SLL), 32'h3, 32'h1F, 32'h0, 5'd16,
           32'h8000_0000, 1'b1, BARREL ? 1 : 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
